seg_display_arbiter: RTL and testbench
======================================

SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DWELL_CYCLES, default 100000000, display hold time per grant in clk cycles (>=2; 1 s at 100 MHz).
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  NUM_REQ  requester i has a number to show.
REQ-006 SHALL have port req_number  input  NUM_REQ x 32  value offered by requester i.
REQ-007 SHALL have port req_ready  output  NUM_REQ  one-hot grant; accept when req_valid[i] & req_ready[i].
REQ-008 SHALL have port idle_number  input  32  value shown when no requester owns the display.
REQ-009 SHALL have port number  output  32  registered value for the seven-segment driver.
REQ-010 SHALL have port owner  output  3  index of current owner; 0 when owner_valid is low.
REQ-011 SHALL have port owner_valid  output  1  high in SHOW state.

Function
REQ-012 SHALL implement two states: IDLE (no owner) and SHOW (owner holding display, dwell counter running).
REQ-013 A grant opportunity SHALL exist in: IDLE; SHOW on the final dwell cycle (counter == DWELL_CYCLES-1); SHOW when req_valid[0] is high and owner != 0 (preemption).
REQ-014 At a grant opportunity, req_ready SHALL be combinational, at most one bit high, and only for a requester with req_valid high; all bits low otherwise.
REQ-015 Requester 0 SHALL have absolute priority; requesters 1..NUM_REQ-1 SHALL be served round-robin starting at the index after the last granted non-zero requester.
REQ-016 On accept, the next cycle SHALL show number = accepted req_number, owner = i, owner_valid = 1, counter = 0, state SHOW.
REQ-017 In SHOW, the counter SHALL increment by 1 per cycle and number SHALL stay frozen at the accepted value.
REQ-018 On the final dwell cycle with no valid requester, the next state SHALL be IDLE with owner_valid = 0 and owner = 0.
REQ-019 On the final dwell cycle with a valid requester, the new grant SHALL take effect with no IDLE cycle in between; the same requester MAY be regranted if it is the only one valid.
REQ-020 Requester 0 SHALL NOT preempt itself; while owner == 0 it is served only at dwell expiry.
REQ-021 In IDLE, number SHALL register idle_number every cycle (one-cycle latency).
REQ-022 A requester dropping req_valid after accept SHALL NOT affect the current dwell.
REQ-023 The round-robin pointer SHALL advance only on accept by a non-zero requester.
REQ-024 The counter SHALL be $clog2(DWELL_CYCLES) bits wide and SHALL never exceed DWELL_CYCLES-1.

Reset
REQ-025 On rst high at a clk edge: state IDLE, number 0, owner 0, owner_valid 0, counter 0, round-robin pointer 1.
REQ-026 While rst is high, req_ready SHALL be all-zero and no accept SHALL occur.
REQ-027 Reset asserted mid-dwell SHALL abandon the dwell; the first post-reset cycle SHALL behave as IDLE.

Structure
REQ-028 Package seg_pkg SHALL hold the state enum (SEG_IDLE, SEG_SHOW) and the default DWELL_CYCLES constant.
REQ-029 Round-robin selection SHALL be a sub-module seg_rr_pick (request vector + pointer in, one-hot grant out, purely combinational).
REQ-030 number SHALL connect directly to the number input of the existing seven-segment driver; this block drives no segments.

Verification (DWELL_CYCLES=8, NUM_REQ=4)
REQ-031 Reset, idle_number=32'hCAFEBABE, no requests -> number=0 during reset, 32'hCAFEBABE one cycle after; owner_valid=0.
REQ-032 req_valid[2] with 32'h00000022 in IDLE -> req_ready=4'b0100 same cycle; number=32'h22, owner=2 for exactly 8 cycles, then IDLE.
REQ-033 req_valid[1] and [3] held continuously -> grants alternate 1,3,1,3 at 8-cycle intervals, no IDLE cycle between them.
REQ-034 Owner 3, req_valid[0] with 32'hDEAD0000 at dwell cycle 3 -> req_ready[0] that cycle; next cycle number=32'hDEAD0000, owner=0, counter restarts.
REQ-035 Owner 0, req_valid[0] held -> no preemption; regrant only at dwell expiry.
REQ-036 rst at dwell cycle 5 -> next cycle all outputs at reset values; a pending request is granted on the first post-reset cycle.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package seg_pkg;

    localparam int unsigned SEG_NUM_W                = 32;
    localparam int unsigned SEG_OWNER_W              = 3;
    localparam int unsigned SEG_DWELL_CYCLES_DEFAULT = 100000000;

    typedef enum logic {
        SEG_IDLE = 1'b0,
        SEG_SHOW = 1'b1
    } seg_state_e;

endpackage : seg_pkg

// File: rtl/seg_rr_pick.sv
// Round-robin one-hot pick among requesters 1..NUM_REQ-1, starting at ptr.
module seg_rr_pick
    import seg_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:1]     req,
    input  logic [SEG_OWNER_W-1:0] ptr,
    output logic [NUM_REQ-1:0]     grant
);

    logic found;

    // Walk NUM_REQ-1 slots from ptr, wrapping back to 1 (slot 0 is never round-robin).
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < int'(NUM_REQ) - 1; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= int'(NUM_REQ)) begin
                idx = idx - (int'(NUM_REQ) - 1);
            end
            for (int j = 1; j < int'(NUM_REQ); j++) begin
                if (!found && (j == idx) && req[j]) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule : seg_rr_pick

// File: rtl/seg_display_arbiter.sv
// Arbitrates which requester's number is shown on the seven-segment display,
// holding each grant for DWELL_CYCLES with requester 0 able to preempt others.
module seg_display_arbiter
    import seg_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DWELL_CYCLES = SEG_DWELL_CYCLES_DEFAULT
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0][SEG_NUM_W-1:0]   req_number,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [SEG_NUM_W-1:0]                idle_number,
    output logic [SEG_NUM_W-1:0]                number,
    output logic [SEG_OWNER_W-1:0]              owner,
    output logic                                owner_valid
);

    localparam int unsigned CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    seg_state_e              state;
    logic [CNT_W-1:0]        dwell_cnt;
    logic [SEG_OWNER_W-1:0]  rr_ptr;

    logic [NUM_REQ-1:0]      rr_grant;
    logic [NUM_REQ-1:0]      pick;
    logic                    dwell_last;
    logic                    opportunity;
    logic                    accept;
    logic [SEG_OWNER_W-1:0]  sel_idx;
    logic [SEG_NUM_W-1:0]    sel_number;
    logic [SEG_OWNER_W-1:0]  nxt_ptr;

    seg_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req   (req_valid[NUM_REQ-1:1]),
        .ptr   (rr_ptr),
        .grant (rr_grant)
    );

    // Grant opportunity and combinational ready; requester 0 always wins.
    always_comb begin
        dwell_last  = (dwell_cnt == CNT_W'(DWELL_CYCLES - 1));
        pick        = req_valid[0] ? NUM_REQ'(1) : rr_grant;
        opportunity = !rst && ((state == SEG_IDLE) ||
                               dwell_last ||
                               (req_valid[0] && (owner != '0)));
        req_ready   = opportunity ? pick : '0;
        accept      = |req_ready;
    end

    // Decode the winning index, its number and the next round-robin start.
    always_comb begin
        sel_idx    = '0;
        sel_number = '0;
        nxt_ptr    = rr_ptr;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (req_ready[i]) begin
                sel_idx    = SEG_OWNER_W'(i);
                sel_number = req_number[i];
                if (i != 0) begin
                    nxt_ptr = (i + 1 == int'(NUM_REQ)) ? SEG_OWNER_W'(1)
                                                       : SEG_OWNER_W'(i + 1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SEG_IDLE;
            number      <= '0;
            owner       <= '0;
            owner_valid <= 1'b0;
            dwell_cnt   <= '0;
            rr_ptr      <= SEG_OWNER_W'(1);
        end else if (accept) begin
            state       <= SEG_SHOW;
            number      <= sel_number;
            owner       <= sel_idx;
            owner_valid <= 1'b1;
            dwell_cnt   <= '0;
            rr_ptr      <= nxt_ptr;
        end else begin
            case (state)
                SEG_IDLE: begin
                    number <= idle_number;
                end
                SEG_SHOW: begin
                    if (dwell_last) begin
                        state       <= SEG_IDLE;
                        owner       <= '0;
                        owner_valid <= 1'b0;
                        dwell_cnt   <= '0;
                    end else begin
                        dwell_cnt <= dwell_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= SEG_IDLE;
                end
            endcase
        end
    end

endmodule : seg_display_arbiter

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with NUM_REQ=4, DWELL_CYCLES=8.
module tb_seg_display_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DWELL   = 8;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0][31:0]  req_number;
    logic [NUM_REQ-1:0]        req_ready;
    logic [31:0]               idle_number;
    logic [31:0]               number;
    logic [2:0]                owner;
    logic                      owner_valid;

    int n_tests;
    int n_fail;

    seg_display_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DWELL_CYCLES (DWELL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_number  (req_number),
        .req_ready   (req_ready),
        .idle_number (idle_number),
        .number      (number),
        .owner       (owner),
        .owner_valid (owner_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change just after the edge, checks follow a settle delay.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        req_valid   = '0;
        req_number  = '0;
        idle_number = 32'hCAFEBABE;

        // Reset: a request while rst is high must not be readied.
        req_valid = 4'b0100;
        step();
        settle();
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_number", number, 32'h0);
        check("rst_owner", 32'(owner), 32'h0);
        check("rst_ov", 32'(owner_valid), 32'h0);
        req_valid = '0;
        step();
        rst = 1'b0;
        step();
        settle();
        check("idle_number", number, 32'hCAFEBABE);
        check("idle_ov", 32'(owner_valid), 32'h0);

        // Single grant to requester 2, held exactly DWELL cycles.
        req_valid     = 4'b0100;
        req_number[2] = 32'h00000022;
        settle();
        check("r2_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        for (int c = 0; c < int'(DWELL); c++) begin
            settle();
            check("r2_number", number, 32'h22);
            check("r2_owner", 32'(owner), 32'h2);
            check("r2_ov", 32'(owner_valid), 32'h1);
            step();
        end
        settle();
        check("r2_end_ov", 32'(owner_valid), 32'h0);
        check("r2_end_owner", 32'(owner), 32'h0);
        step();
        settle();
        check("r2_idle_number", number, 32'hCAFEBABE);

        // Requesters 1 and 3 held: pointer sits at 3 after granting 2, so 3,1,3,1.
        req_valid     = 4'b1010;
        req_number[1] = 32'h00000011;
        req_number[3] = 32'h00000033;
        settle();
        check("rr_first_ready", 32'(req_ready), 32'h8);
        step();
        for (int g = 0; g < 4; g++) begin
            logic [31:0] exp_owner;
            logic [31:0] exp_num;
            logic [31:0] exp_next;
            exp_owner = (g % 2 == 0) ? 32'h3 : 32'h1;
            exp_num   = (g % 2 == 0) ? 32'h33 : 32'h11;
            exp_next  = (g % 2 == 0) ? 32'h2 : 32'h8;
            for (int c = 0; c < int'(DWELL); c++) begin
                settle();
                check("rr_owner", 32'(owner), exp_owner);
                check("rr_number", number, exp_num);
                check("rr_ov", 32'(owner_valid), 32'h1);
                check("rr_ready", 32'(req_ready), (c == int'(DWELL) - 1) ? exp_next : 32'h0);
                step();
            end
        end

        // Owner 3 again; requester 3 drops, dwell continues; preempt at dwell cycle 3.
        req_valid = '0;
        step();
        step();
        step();
        req_valid     = 4'b0001;
        req_number[0] = 32'hDEAD0000;
        settle();
        check("pre_owner", 32'(owner), 32'h3);
        check("pre_ready", 32'(req_ready), 32'h1);
        step();
        req_number[0] = 32'hDEAD0001;

        // Requester 0 held: no self-preemption, regrant only when the restarted dwell expires.
        for (int c = 0; c < int'(DWELL); c++) begin
            settle();
            check("r0_number", number, 32'hDEAD0000);
            check("r0_owner", 32'(owner), 32'h0);
            check("r0_ov", 32'(owner_valid), 32'h1);
            check("r0_ready", 32'(req_ready), (c == int'(DWELL) - 1) ? 32'h1 : 32'h0);
            step();
        end
        settle();
        check("r0_regrant_number", number, 32'hDEAD0001);
        check("r0_regrant_ov", 32'(owner_valid), 32'h1);

        // Reset at dwell cycle 5 with a pending request from requester 2.
        req_valid = '0;
        for (int c = 0; c < 5; c++) step();
        rst       = 1'b1;
        req_valid = 4'b0100;
        settle();
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        step();
        settle();
        check("mid_rst_number", number, 32'h0);
        check("mid_rst_owner", 32'(owner), 32'h0);
        check("mid_rst_ov", 32'(owner_valid), 32'h0);
        rst = 1'b0;
        settle();
        check("post_rst_ready", 32'(req_ready), 32'h4);
        step();
        settle();
        check("post_rst_owner", 32'(owner), 32'h2);
        check("post_rst_number", number, 32'h22);
        check("post_rst_ov", 32'(owner_valid), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_seg_display_arbiter
